// File: rtl/seq_det_sched_if.sv
// Word-level request/grant bundle plus the bit-level link to the external
// sequence detector, shared by the scheduler and whatever sits around it.
interface seq_det_sched_if #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
);
  logic             req0;
  logic [WIDTH-1:0] data0;
  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [CW-1:0]    match_cnt;
  logic             det_reset;
  logic             det_ip;
  logic             det_op;

  modport master (
    output req0, data0, req1, data1, det_op,
    input  gnt0, gnt1, busy, done, done_id, match_cnt, det_reset, det_ip
  );

  modport slave (
    input  req0, data0, req1, data1, det_op,
    output gnt0, gnt1, busy, done, done_id, match_cnt, det_reset, det_ip
  );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin scheduler that feeds one word at a time, MSB first, into a shared
// serial Moore detector and reports how many cycles its output was high.
module seq_det_sched #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  seq_det_sched_if.slave    bus
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    match_q;
  logic             last_id;
  logic             owner;
  logic             win_id;
  logic             det_reset_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win_id = bus.req1;
    if (bus.req0 && bus.req1) begin
      win_id = ~last_id;
    end
  end

  assign cnt_inc = (bus.det_op && (cnt != CNT_MAX)) ? cnt + 1'b1 : cnt;

  always_comb begin
    state_nxt     = state;
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    bus.det_ip    = 1'b0;
    bus.done_id   = owner;
    bus.match_cnt = match_q;
    bus.det_reset = det_reset_q;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt = CLR;
        end
      end
      CLR: begin
        bus.gnt0  = ~owner;
        bus.gnt1  = owner;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.det_ip = sreg[WIDTH-1];
        if (idx == LAST_IDX) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The detector output in the first SHIFT cycle still shows its reset state,
  // so counting starts one cycle late and finishes in DRAIN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sreg        <= '0;
      idx         <= '0;
      cnt         <= '0;
      match_q     <= '0;
      last_id     <= 1'b1;
      owner       <= 1'b0;
      det_reset_q <= 1'b1;
    end else begin
      state       <= state_nxt;
      det_reset_q <= (state_nxt == CLR);
      case (state)
        IDLE: begin
          if (state_nxt == CLR) begin
            sreg  <= win_id ? bus.data1 : bus.data0;
            owner <= win_id;
          end
        end
        CLR: begin
          cnt <= '0;
          idx <= '0;
        end
        SHIFT: begin
          sreg <= sreg << 1;
          idx  <= idx + 1'b1;
          if (idx != '0) begin
            cnt <= cnt_inc;
          end
        end
        DRAIN: begin
          cnt     <= cnt_inc;
          match_q <= cnt_inc;
        end
        DONE: begin
          last_id <= owner;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: a behavioural overlapping "101" detector, a
// cycle-offset transaction model checked every cycle, and directed scenarios.
module tb_seq_det_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_det_sched_if #(.WIDTH(W), .CW(4)) bus ();
  seq_det_sched_if #(.WIDTH(W), .CW(2)) bus2 ();

  seq_det_sched #(.WIDTH(W), .CW(4)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  seq_det_sched #(.WIDTH(W), .CW(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  // The narrow-counter copy sees the same requests but a detector stuck at 1.
  assign bus2.req0   = bus.req0;
  assign bus2.data0  = bus.data0;
  assign bus2.req1   = bus.req1;
  assign bus2.data1  = bus.data1;
  assign bus2.det_op = 1'b1;

  logic [2:0] hist = 3'b000;
  int         nbits = 0;
  always @(posedge clk) begin
    if (bus.det_reset) begin
      hist  <= 3'b000;
      nbits <= 0;
    end else begin
      hist <= {hist[1:0], bus.det_ip};
      if (nbits < 3) nbits <= nbits + 1;
    end
  end
  assign bus.det_op = (nbits >= 3) && (hist == 3'b101);

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sat_seen = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int count101(input logic [W-1:0] w);
    int n = 0;
    for (int i = W - 1; i >= 2; i--) begin
      if (w[i] && !w[i-1] && w[i-2]) n++;
    end
    return (n > 15) ? 15 : n;
  endfunction

  bit             m_on = 0;
  bit             m_act = 0;
  bit             m_win = 0;
  bit             m_last = 1;
  bit             m_did = 0;
  bit             m_rst_prev = 1;
  int             m_t = 0;
  int             m_exp = 0;
  int             m_match = 0;
  logic [W-1:0]   m_word = '0;

  // Transaction model: everything is expressed as an offset from the cycle in
  // which the request was taken.
  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; m_last = 1; m_did = 0; m_match = 0; m_rst_prev = 1; m_on = 1;
    end else begin
      m_rst_prev = 0;
      if (m_act) begin
        if (cyc - m_t == W + 2) m_match = m_exp;
        if (cyc - m_t == W + 3) begin
          m_act = 0;
          m_last = m_win;
        end
      end else if (bus.req0 || bus.req1) begin
        m_win  = (bus.req0 && bus.req1) ? ~m_last : bus.req1;
        m_word = m_win ? bus.data1 : bus.data0;
        m_did  = m_win;
        m_t    = cyc;
        m_act  = 1;
        m_exp  = count101(m_word);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    int   k;
    logic exp_ip;
    if (m_on) begin
      k = cyc - m_t;
      exp_ip = 1'b0;
      if (m_act && k >= 2 && k <= W + 1) exp_ip = m_word[W+1-k];
      checkOutput("busy",      int'(bus.busy),      int'(m_act));
      checkOutput("gnt0",      int'(bus.gnt0),      int'(m_act && k == 1 && !m_win));
      checkOutput("gnt1",      int'(bus.gnt1),      int'(m_act && k == 1 && m_win));
      checkOutput("done",      int'(bus.done),      int'(m_act && k == W + 3));
      checkOutput("done_id",   int'(bus.done_id),   int'(m_did));
      checkOutput("match_cnt", int'(bus.match_cnt), m_match);
      checkOutput("det_reset", int'(bus.det_reset), int'((m_act && k == 1) || m_rst_prev));
      checkOutput("det_ip",    int'(bus.det_ip),    int'(exp_ip));
      if (bus2.done) begin
        sat_seen++;
        checkOutput("sat_cnt", int'(bus2.match_cnt), 3);
      end
    end
  end

  int           g_cyc[$];
  bit           g_id[$];
  int           d_cyc[$];
  bit           d_id[$];
  int           d_cnt[$];
  int           t0;
  logic [W-1:0] ip_bits;

  task automatic applyStimulus(input logic r0, input logic [W-1:0] d0,
                               input logic r1, input logic [W-1:0] d1);
    @(negedge clk);
    #2;
    bus.req0 = r0; bus.data0 = d0; bus.req1 = r1; bus.data1 = d1;
  endtask

  task automatic runWindow(input logic r0, input logic [W-1:0] d0,
                           input logic r1, input logic [W-1:0] d1,
                           input bit hold, input logic [W-1:0] d0_after, input int ncyc);
    g_cyc.delete(); g_id.delete(); d_cyc.delete(); d_id.delete(); d_cnt.delete();
    ip_bits = '0;
    applyStimulus(r0, d0, r1, d1);
    t0 = cyc;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        g_cyc.push_back(cyc - t0);
        g_id.push_back(bus.gnt1);
      end
      if (bus.done) begin
        d_cyc.push_back(cyc - t0);
        d_id.push_back(bus.done_id);
        d_cnt.push_back(int'(bus.match_cnt));
      end
      if (g_cyc.size() == 1 && cyc - t0 >= 2 && cyc - t0 <= W + 1)
        ip_bits[W+1-(cyc-t0)] = bus.det_ip;
      #1;
      if (bus.gnt0) begin
        if (hold) bus.data0 = d0_after;
        else bus.req0 = 1'b0;
      end
      if (bus.gnt1 && !hold) bus.req1 = 1'b0;
    end
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    checkOutput("idle_timeout", int'(idle), 1);
  endtask

  task automatic doReset();
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk); #2 reset = 1'b0;
  endtask

  task automatic expectGnt(input string name, input int idx, input int when, input int id);
    if (g_cyc.size() > idx) begin
      checkOutput({name, "_gnt_cyc"}, g_cyc[idx], when);
      checkOutput({name, "_gnt_id"}, int'(g_id[idx]), id);
    end else begin
      checkOutput({name, "_gnt_missing"}, g_cyc.size(), idx + 1);
    end
  endtask

  task automatic expectDone(input string name, input int idx, input int when, input int id, input int cnt);
    if (d_cyc.size() > idx) begin
      checkOutput({name, "_done_cyc"}, d_cyc[idx], when);
      checkOutput({name, "_done_id"}, int'(d_id[idx]), id);
      checkOutput({name, "_done_cnt"}, d_cnt[idx], cnt);
    end else begin
      checkOutput({name, "_done_missing"}, d_cyc.size(), idx + 1);
    end
  endtask

  initial begin
    int ndone;
    bus.req0 = 1'b0; bus.data0 = '0; bus.req1 = 1'b0; bus.data1 = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt0", int'(bus.gnt0), 0);
    checkOutput("rst_gnt1", int'(bus.gnt1), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_done_id", int'(bus.done_id), 0);
    checkOutput("rst_match", int'(bus.match_cnt), 0);
    checkOutput("rst_match2", int'(bus2.match_cnt), 0);
    checkOutput("rst_det_ip", int'(bus.det_ip), 0);
    checkOutput("rst_det_reset", int'(bus.det_reset), 1);
    #2 reset = 1'b0;

    $display("[TB] single request, word 1010_1011");
    runWindow(1'b1, 8'b1010_1011, 1'b0, 8'h00, 1'b0, 8'h00, 16);
    expectGnt("t1", 0, 1, 0);
    expectDone("t1", 0, 11, 0, 3);
    checkOutput("t1_ip_bits", int'(ip_bits), int'(8'b1010_1011));
    waitIdle();

    $display("[TB] tie after req0 was served");
    runWindow(1'b1, 8'h5A, 1'b1, 8'h0A, 1'b0, 8'h00, 28);
    expectGnt("alt", 0, 1, 1);
    expectGnt("alt", 1, 13, 0);
    expectDone("alt", 0, 11, 1, 1);
    expectDone("alt", 1, 23, 0, 2);
    waitIdle();

    $display("[TB] tie right after reset");
    doReset();
    runWindow(1'b1, 8'hA5, 1'b1, 8'hFF, 1'b0, 8'h00, 28);
    expectGnt("tie", 0, 1, 0);
    expectGnt("tie", 1, 13, 1);
    expectDone("tie", 0, 11, 0, 2);
    expectDone("tie", 1, 23, 1, 0);
    waitIdle();
    runWindow(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 28);
    expectGnt("tie2", 0, 1, 0);
    expectGnt("tie2", 1, 13, 1);
    waitIdle();

    $display("[TB] req1 only, held");
    runWindow(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 40);
    checkOutput("r1_gnt_count", g_cyc.size(), 4);
    for (int i = 0; i < 4; i++) expectGnt("r1", i, 1 + 12 * i, 1);
    for (int i = 0; i < 3; i++) expectDone("r1", i, 11 + 12 * i, 1, 0);
    waitIdle();

    $display("[TB] reset in the fourth shift cycle");
    applyStimulus(1'b1, 8'b1010_1011, 1'b0, 8'h00);
    t0 = cyc;
    @(negedge clk);
    checkOutput("mid_gnt0", int'(bus.gnt0), 1);
    #1 bus.req0 = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_busy", int'(bus.busy), 0);
    checkOutput("mid_det_reset", int'(bus.det_reset), 1);
    checkOutput("mid_match", int'(bus.match_cnt), 0);
    #2 reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    checkOutput("mid_no_done", ndone, 0);
    runWindow(1'b1, 8'b1010_1011, 1'b0, 8'h00, 1'b0, 8'h00, 16);
    expectGnt("post", 0, 1, 0);
    expectDone("post", 0, 11, 0, 3);
    waitIdle();

    $display("[TB] req0 held, data changed after grant");
    runWindow(1'b1, 8'b1010_1011, 1'b0, 8'h00, 1'b1, 8'h00, 16);
    checkOutput("hold_gnt_count", g_cyc.size(), 2);
    expectGnt("hold", 0, 1, 0);
    expectGnt("hold", 1, 13, 0);
    expectDone("hold", 0, 11, 0, 3);
    waitIdle();

    checkOutput("sat_seen", int'(sat_seen > 0), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
